// File: rtl/calc1_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc1_port_arbiter
// Purpose  : Shares one calculator ALU between four two-cycle requester ports,
//            round-robin, one op outstanding, with response routing + timeout.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [0:CMD_W-1]  req1_cmd_in,
  input  logic [0:CMD_W-1]  req2_cmd_in,
  input  logic [0:CMD_W-1]  req3_cmd_in,
  input  logic [0:CMD_W-1]  req4_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:1]        out_resp1,
  output logic [0:1]        out_resp2,
  output logic [0:1]        out_resp3,
  output logic [0:1]        out_resp4,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:DATA_W-1] out_data4,
  output logic              alu_req_valid,
  output logic [0:CMD_W-1]  alu_cmd,
  output logic [0:DATA_W-1] alu_op1,
  output logic [0:DATA_W-1] alu_op2,
  output logic [0:1]        alu_req_tag,
  input  logic              alu_rsp_valid,
  input  logic [0:1]        alu_rsp_tag,
  input  logic [0:1]        alu_rsp_resp,
  input  logic [0:DATA_W-1] alu_rsp_data,
  output logic [0:3]        drop_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OP2     = 2'd1,
    ST_PENDING = 2'd2,
    ST_ISSUED  = 2'd3
  } port_state_t;

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [0:CMD_W-1]  w_cmd_in  [4];
  logic [0:DATA_W-1] w_data_in [4];

  port_state_t       r_state   [4];
  port_state_t       w_state_nx[4];
  logic [0:CMD_W-1]  r_cmd     [4];
  logic [0:DATA_W-1] r_op1     [4];
  logic [0:DATA_W-1] r_op2     [4];
  logic [1:0]        r_resp    [4];
  logic [0:DATA_W-1] r_rdata   [4];
  logic [0:3]        r_drop;

  logic [3:0]        w_elig;
  logic [3:0]        w_done;
  logic [3:0]        w_drop_set;
  logic [1:0]        w_scan;
  logic [1:0]        w_grant_idx;
  logic              w_grant_any;
  logic [0:DATA_W-1] w_op2_sel;

  logic              r_busy;
  logic [1:0]        r_tag;
  logic [c_CNT_W-1:0] r_tmo_cnt;
  logic [1:0]        r_rr_ptr;
  logic              w_rsp_hit;
  logic              w_tmo_fire;
  logic              w_free_next;

  logic              r_req_valid;
  logic [0:CMD_W-1]  r_req_cmd;
  logic [0:DATA_W-1] r_req_op1;
  logic [0:DATA_W-1] r_req_op2;
  logic [1:0]        r_req_tag;

  always_comb begin
    w_cmd_in[0]  = req1_cmd_in;
    w_cmd_in[1]  = req2_cmd_in;
    w_cmd_in[2]  = req3_cmd_in;
    w_cmd_in[3]  = req4_cmd_in;
    w_data_in[0] = req1_data_in;
    w_data_in[1] = req2_data_in;
    w_data_in[2] = req3_data_in;
    w_data_in[3] = req4_data_in;
  end

  // The grant is registered, so it looks one cycle ahead: a port in OP2 is
  // PENDING next cycle, and a matching response/timeout frees the ALU now.
  always_comb begin
    w_rsp_hit   = r_busy && alu_rsp_valid && (alu_rsp_tag == r_tag);
    w_tmo_fire  = r_busy && !w_rsp_hit && (r_tmo_cnt == c_TMO_LAST);
    w_free_next = !r_busy || w_rsp_hit || w_tmo_fire;
    for (int p = 0; p < 4; p++) begin
      w_elig[p] = (r_state[p] == ST_OP2) || (r_state[p] == ST_PENDING);
    end
    w_grant_any = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_scan      = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      w_scan = r_rr_ptr + 2'(i);
      if (w_free_next && !w_grant_any && w_elig[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan;
      end
    end
    w_op2_sel = (r_state[w_grant_idx] == ST_OP2) ? w_data_in[w_grant_idx]
                                                 : r_op2[w_grant_idx];
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_state_nx[p] = r_state[p];
      w_drop_set[p] = 1'b0;
      w_done[p]     = (w_rsp_hit || w_tmo_fire) && (r_tag == 2'(p));
      case (r_state[p])
        ST_IDLE: begin
          if (w_cmd_in[p] != '0) w_state_nx[p] = ST_OP2;
        end
        ST_OP2: begin
          w_state_nx[p] = (w_grant_any && (w_grant_idx == 2'(p))) ? ST_ISSUED : ST_PENDING;
        end
        ST_PENDING: begin
          if (w_grant_any && (w_grant_idx == 2'(p))) w_state_nx[p] = ST_ISSUED;
          w_drop_set[p] = (w_cmd_in[p] != '0);
        end
        default: begin
          if (w_done[p]) w_state_nx[p] = ST_IDLE;
          w_drop_set[p] = (w_cmd_in[p] != '0);
        end
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 4; p++) begin
        r_state[p] <= ST_IDLE;
        r_cmd[p]   <= '0;
        r_op1[p]   <= '0;
        r_op2[p]   <= '0;
        r_resp[p]  <= 2'd0;
        r_rdata[p] <= '0;
      end
      r_drop <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        r_state[p] <= w_state_nx[p];
        if ((r_state[p] == ST_IDLE) && (w_cmd_in[p] != '0)) begin
          r_cmd[p] <= w_cmd_in[p];
          r_op1[p] <= w_data_in[p];
        end
        if (r_state[p] == ST_OP2) r_op2[p] <= w_data_in[p];
        if (w_drop_set[p]) r_drop[p] <= 1'b1;
        if (w_done[p]) begin
          r_resp[p]  <= w_rsp_hit ? alu_rsp_resp : 2'd3;
          r_rdata[p] <= w_rsp_hit ? alu_rsp_data : '0;
        end else begin
          r_resp[p]  <= 2'd0;
          r_rdata[p] <= '0;
        end
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy      <= 1'b0;
      r_tag       <= 2'd0;
      r_tmo_cnt   <= '0;
      r_rr_ptr    <= 2'd0;
      r_req_valid <= 1'b0;
      r_req_cmd   <= '0;
      r_req_op1   <= '0;
      r_req_op2   <= '0;
      r_req_tag   <= 2'd0;
    end else if (w_grant_any) begin
      r_busy      <= 1'b1;
      r_tag       <= w_grant_idx;
      r_tmo_cnt   <= '0;
      r_rr_ptr    <= w_grant_idx + 2'd1;
      r_req_valid <= 1'b1;
      r_req_cmd   <= r_cmd[w_grant_idx];
      r_req_op1   <= r_op1[w_grant_idx];
      r_req_op2   <= w_op2_sel;
      r_req_tag   <= w_grant_idx;
    end else begin
      r_req_valid <= 1'b0;
      r_req_cmd   <= '0;
      r_req_op1   <= '0;
      r_req_op2   <= '0;
      r_req_tag   <= 2'd0;
      if (w_rsp_hit || w_tmo_fire) begin
        r_busy    <= 1'b0;
        r_tmo_cnt <= '0;
      end else if (r_busy) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign alu_req_valid = r_req_valid;
  assign alu_cmd       = r_req_cmd;
  assign alu_op1       = r_req_op1;
  assign alu_op2       = r_req_op2;
  assign alu_req_tag   = r_req_tag;
  assign out_resp1     = r_resp[0];
  assign out_resp2     = r_resp[1];
  assign out_resp3     = r_resp[2];
  assign out_resp4     = r_resp[3];
  assign out_data1     = r_rdata[0];
  assign out_data2     = r_rdata[1];
  assign out_data3     = r_rdata[2];
  assign out_data4     = r_rdata[3];
  assign drop_sticky   = r_drop;

endmodule
`default_nettype wire

// File: doc/calc1_port_arbiter.md
Name: calc1_port_arbiter

Overview:
Front-end scheduler that shares a single calculator ALU between four requester ports. Each port issues a two-cycle request: a command plus operand 1, then operand 2. The block captures requests per port and grants the ALU round-robin with one operation outstanding at a time. It routes each ALU result back to the originating port as a one-cycle response, and times out hung operations.

Parameters:
DATA_W, 32, operand/result width
CMD_W, 4, command width
TIMEOUT, 64, cycles from issue to forced timeout response (>=2)

Ports:
c_clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
reqN_cmd_in (N=1..4)  in  [0:CMD_W-1]  command; 0 = no request
reqN_data_in (N=1..4)  in  [0:DATA_W-1]  operand 1 in cmd cycle, operand 2 in following cycle
out_respN (N=1..4)  out  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid (from ALU), 3 timeout
out_dataN (N=1..4)  out  [0:DATA_W-1]  result, valid only when out_respN != 0
alu_req_valid  out  1  one-cycle issue strobe
alu_cmd  out  [0:CMD_W-1]  issued command
alu_op1, alu_op2  out  [0:DATA_W-1]  issued operands
alu_req_tag  out  [0:1]  issuing port index (0 = port 1)
alu_rsp_valid  in  1  ALU result strobe
alu_rsp_tag  in  [0:1]  echoed tag
alu_rsp_resp  in  [0:1]  ALU response code
alu_rsp_data  in  [0:DATA_W-1]  ALU result
drop_sticky  out  [0:3]  bit N-1 set when port N sent a cmd while busy

Behaviour:
- Reset (async, on reset_n low): all ports go to IDLE; pending requests are discarded. RR pointer = port 1. ALU goes to FREE. All outputs are 0. drop_sticky is cleared. A reset mid-operation abandons the in-flight op; a later response is ignored.
- Per-port FSM:
  - IDLE -> OP2 on a cycle with cmd != 0; cmd and data are latched as operand 1.
  - OP2 -> PENDING unconditionally; data is latched as operand 2 and cmd is ignored.
  - PENDING -> ISSUED when the port is granted.
  - ISSUED -> IDLE at the edge that registers its response.
- A nonzero cmd seen in PENDING or ISSUED is dropped and sets drop_sticky[N-1]. The cmd cycle sees OP2 as busy, so the cmd is ignored without setting drop_sticky.
- The arbiter forwards every nonzero cmd value to the ALU; it does not validate cmds. Invalid-command reporting belongs to the ALU.
- Grant:
  - Evaluated only when the ALU is FREE.
  - Round-robin among PENDING ports, starting from the RR pointer. After granting port k, the pointer moves to k+1 (mod 4).
  - At grant, alu_req_valid is high for exactly one cycle with the latched cmd, op1, op2 and tag; the ALU then goes to BUSY.
- Latency: cmd in cycle T, op2 in T+1, earliest alu_req_valid in T+2.
- Response:
  - An alu_rsp_valid in cycle R with alu_rsp_tag equal to the outstanding tag while BUSY produces out_respN = alu_rsp_resp and out_dataN = alu_rsp_data for exactly cycle R+1 on that port.
  - The ALU goes FREE and the earliest next issue is R+1.
  - The port is IDLE in R+1 and accepts a new cmd in R+1.
- Stale response: alu_rsp_valid with a mismatched tag, or while FREE, is ignored and produces no port output.
- Timeout:
  - A counter starts at issue.
  - If no matching response arrives within TIMEOUT cycles of the issue cycle, the owner gets out_resp = 3 and out_data = 0 for one cycle.
  - The ALU goes FREE and a later matching response is ignored.
  - A response in the same cycle the timeout fires takes precedence; the timeout does not fire.
- Outputs are registered. out_respN/out_dataN return to 0 the cycle after the response pulse.

Test Plan:
- Port 1 sends cmd=1, 0x0000_0001 then 0x1FFF_FFFF; ALU model answers resp 1, data 0x2000_0000 after 3 cycles -> alu_req_valid in T+2 with op1=1, op2=0x1FFF_FFFF, tag 0; out_resp1=1, out_data1=0x2000_0000 for one cycle; all other ports stay 0.
- All four ports issue cmd=1 in the same cycle, ALU latency 1 -> grants in order 1,2,3,4, one outstanding at a time, each response routed to the correct port. Repeat with ports 1 and 2 pending after port 1 was last granted -> port 2 is granted first.
- Port 3 sends cmd=2, op1=1, op2=0xF; ALU returns resp 2 -> out_resp3=2 and data as returned. Port 3 sends cmd=4; ALU returns resp 2 -> out_resp3=2, confirming the arbiter forwarded cmd=4 unchanged.
- ALU model never responds -> out_resp1=3, out_data1=0 exactly TIMEOUT cycles after issue. A late alu_rsp_valid with tag 0 is ignored, and the next pending port is issued the following cycle.
- Port 2 asserts cmd=1 while in PENDING -> request dropped, drop_sticky=4'b0100. Assert reset_n low while port 2 is ISSUED -> all outputs 0 immediately, drop_sticky cleared, and the later ALU response produces no out_resp2.
